// File: rtl/display_scan_7seg.sv
// Four-digit multiplexed 7-segment scanner for the mm:ss timer: latches the BCD
// digits once per frame and drives one digit enable at a time with a guard gap.
module display_scan_7seg #(
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD        = 16,
    parameter int BLINK_FRAMES = 125,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] dig3,
    input  logic [3:0] dig2,
    input  logic [3:0] dig1,
    input  logic [3:0] dig0,
    input  logic       lz_en,
    input  logic       blink_en,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame_start
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD);
    localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(BLINK_FRAMES - 1);
    localparam logic [6:0]       SEG_OFF   = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0]       AN_OFF    = ACTIVE_LOW ? 4'hF : 4'h0;

    typedef enum logic [1:0] {
        SLOT_D1 = 2'd0,
        SLOT_D2 = 2'd1,
        SLOT_D3 = 2'd2,
        SLOT_D4 = 2'd3
    } slot_e;

    // Active-high {g,f,e,d,c,b,a}; non-BCD codes render as a centre dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'd0:    pat = 7'b0111111;
            4'd1:    pat = 7'b0000110;
            4'd2:    pat = 7'b1011011;
            4'd3:    pat = 7'b1001111;
            4'd4:    pat = 7'b1100110;
            4'd5:    pat = 7'b1101101;
            4'd6:    pat = 7'b1111101;
            4'd7:    pat = 7'b0000111;
            4'd8:    pat = 7'b1111111;
            4'd9:    pat = 7'b1101111;
            default: pat = 7'b1000000;
        endcase
        return pat;
    endfunction

    logic             start_q, start_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    slot_e            slot_q, slot_d;
    logic [3:0]       shadow_q [4];
    logic [3:0]       shadow_d [4];
    logic [FC_W-1:0]  fc_q, fc_d;
    logic             phase_on_q, phase_on_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic             frame_start_q, frame_start_d;

    logic             slot_wrap;
    logic             frame_load;
    logic             lz_blank;
    logic             show_en;
    logic [1:0]       slot_idx;
    logic [3:0]       cur_digit;
    logic [6:0]       seg_act;
    logic [3:0]       an_act;
    logic [3:0]       dig_in [4];

    // Slot 0 is the leftmost position (d1, minutes tens).
    assign dig_in[0] = dig3;
    assign dig_in[1] = dig2;
    assign dig_in[2] = dig1;
    assign dig_in[3] = dig0;

    assign slot_idx  = slot_q;
    assign cur_digit = shadow_q[slot_idx];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            assign shadow_d[gi] = frame_load ? dig_in[gi] : shadow_q[gi];
            assign an_act[gi]   = show_en && (slot_idx == 2'(gi));
        end
    endgenerate

    always_comb begin
        slot_wrap  = (cnt_q == CNT_LAST);
        frame_load = start_q || (slot_wrap && (slot_q == SLOT_D4));

        // The post-reset load cycle holds the scan so d1 slot then starts at count 0.
        start_d = 1'b0;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        if (!start_q) begin
            if (slot_wrap) begin
                cnt_d  = '0;
                slot_d = slot_e'(slot_idx + 2'd1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        fc_d       = fc_q;
        phase_on_d = phase_on_q;
        if (!blink_en) begin
            fc_d       = '0;
            phase_on_d = 1'b1;
        end else if (frame_load) begin
            if (fc_q == FC_LAST) begin
                fc_d       = '0;
                phase_on_d = ~phase_on_q;
            end else begin
                fc_d = fc_q + FC_W'(1);
            end
        end

        lz_blank = lz_en && (slot_q == SLOT_D1) && (shadow_q[0] == 4'd0);
        show_en  = !start_q && phase_on_q && (cnt_q >= GUARD_CNT) && !lz_blank;

        seg_act       = seg_decode(cur_digit);
        seg_d         = start_q ? SEG_OFF : (ACTIVE_LOW ? ~seg_act : seg_act);
        an_d          = ACTIVE_LOW ? ~an_act : an_act;
        frame_start_d = frame_load;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            start_q       <= 1'b1;
            cnt_q         <= '0;
            slot_q        <= SLOT_D1;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= 4'd0;
            end
            fc_q          <= '0;
            phase_on_q    <= 1'b1;
            seg_q         <= SEG_OFF;
            an_q          <= AN_OFF;
            frame_start_q <= 1'b0;
        end else begin
            start_q       <= start_d;
            cnt_q         <= cnt_d;
            slot_q        <= slot_d;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
            fc_q          <= fc_d;
            phase_on_q    <= phase_on_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule
